// File: rtl/tilemap_gen.sv
// Tile-map background renderer for an LCD scanout: scroll/wrap, map lookup,
// pattern row fetch and palette lookup in a fixed 4-cycle pipeline.
module tilemap_gen #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [$clog2(WIDTH)-1:0]  hpos,
  input  logic [$clog2(HEIGHT)-1:0] vpos,
  input  logic                      vsync,
  input  logic                      wr_en,
  input  logic [1:0]                wr_sel,
  input  logic [11:0]               wr_addr,
  input  logic [15:0]               wr_data,
  output logic [4:0]                red,
  output logic [5:0]                green,
  output logic [4:0]                blue,
  output logic                      pix_valid
);

  localparam int HW       = $clog2(WIDTH);
  localparam int VW       = $clog2(HEIGHT);
  localparam int COLS     = WIDTH / 8;
  localparam int ROWS     = HEIGHT / 8;
  localparam int MAP_SIZE = COLS * ROWS;
  localparam int MAW      = $clog2(MAP_SIZE);

  localparam logic [HW:0]      W_L        = (HW+1)'(WIDTH);
  localparam logic [VW:0]      H_L        = (VW+1)'(HEIGHT);
  localparam logic [12:0]      MAP_SIZE_L = 13'(MAP_SIZE);
  localparam logic [MAW-1:0]   COLS_L     = MAW'(COLS);
  localparam logic [2:0]       STAB_N     = 3'd4;

  localparam logic [1:0] SEL_MAP    = 2'd0;
  localparam logic [1:0] SEL_PAT    = 2'd1;
  localparam logic [1:0] SEL_PAL    = 2'd2;
  localparam logic [1:0] SEL_SCROLL = 2'd3;

  // Scroll values beyond the visible area clamp to the last column/line so
  // the single conditional subtract in stage 1 always yields a valid coordinate.
  function automatic logic [HW-1:0] sat_hscroll(input logic [8:0] v);
    if (32'(v) >= WIDTH) sat_hscroll = HW'(WIDTH - 1);
    else                 sat_hscroll = HW'(v);
  endfunction

  function automatic logic [VW-1:0] sat_vscroll(input logic [7:0] v);
    if (32'(v) >= HEIGHT) sat_vscroll = VW'(HEIGHT - 1);
    else                  sat_vscroll = VW'(v);
  endfunction

  function automatic logic [HW-1:0] wrap_x(input logic [HW:0] s);
    if (s >= W_L) wrap_x = HW'(s - W_L);
    else          wrap_x = HW'(s);
  endfunction

  function automatic logic [VW-1:0] wrap_y(input logic [VW:0] s);
    if (s >= H_L) wrap_y = VW'(s - H_L);
    else          wrap_y = VW'(s);
  endfunction

  // Map and pattern memories are deliberately left out of reset.
  logic [7:0]  map_mem [MAP_SIZE];
  logic [15:0] pat_mem [4096];

  logic map_we, pat_we;

  always_comb begin
    map_we = wr_en && (wr_sel == SEL_MAP) && ({1'b0, wr_addr} < MAP_SIZE_L);
    pat_we = wr_en && (wr_sel == SEL_PAT);
  end

  always_ff @(posedge clk) begin
    if (map_we) map_mem[wr_addr[MAW-1:0]] <= wr_data[7:0];
    if (pat_we) pat_mem[wr_addr]          <= wr_data;
  end

  logic [15:0]   pal_q [16];
  logic [15:0]   pal_d [16];
  logic [8:0]    hpend_q, hpend_d;
  logic [7:0]    vpend_q, vpend_d;
  logic [HW-1:0] hscroll_q, hscroll_d;
  logic [VW-1:0] vscroll_q, vscroll_d;
  logic          vsync_q, vsync_d;
  logic [HW-1:0] prev_h_q, prev_h_d;
  logic [VW-1:0] prev_v_q, prev_v_d;
  logic [2:0]    stab_cnt_q, stab_cnt_d;
  logic          pix_valid_q, pix_valid_d;

  logic [HW-1:0] x_p1_q, x_p1_d;
  logic [VW-1:0] y_p1_q, y_p1_d;
  logic          oor_p1_q, oor_p1_d;
  logic [7:0]    tile_p2_q, tile_p2_d;
  logic [2:0]    xlo_p2_q, xlo_p2_d;
  logic [2:0]    ylo_p2_q, ylo_p2_d;
  logic          oor_p2_q, oor_p2_d;
  logic [31:0]   row_p3_q, row_p3_d;
  logic [2:0]    xlo_p3_q, xlo_p3_d;
  logic          oor_p3_q, oor_p3_d;
  logic [15:0]   rgb_p4_q, rgb_p4_d;

  logic          in_range;
  logic          same_pos;
  logic [HW:0]   hsum;
  logic [VW:0]   vsum;
  logic [MAW-1:0] map_raddr;
  logic [4:0]    nib_shift;
  logic [3:0]    nibble;

  // Register writes and frame-boundary scroll update
  always_comb begin
    pal_d   = pal_q;
    hpend_d = hpend_q;
    vpend_d = vpend_q;
    if (wr_en && (wr_sel == SEL_PAL)) pal_d[wr_addr[3:0]] = wr_data;
    if (wr_en && (wr_sel == SEL_SCROLL) && (wr_addr == 12'd0)) hpend_d = wr_data[8:0];
    if (wr_en && (wr_sel == SEL_SCROLL) && (wr_addr == 12'd1)) vpend_d = wr_data[7:0];

    vsync_d   = vsync;
    hscroll_d = hscroll_q;
    vscroll_d = vscroll_q;
    if (vsync && !vsync_q) begin
      hscroll_d = sat_hscroll(hpend_q);
      vscroll_d = sat_vscroll(vpend_q);
    end
  end

  // Position stability tracking for pix_valid
  always_comb begin
    in_range   = ({1'b0, hpos} < W_L) && ({1'b0, vpos} < H_L);
    same_pos   = (hpos == prev_h_q) && (vpos == prev_v_q);
    prev_h_d   = hpos;
    prev_v_d   = vpos;
    if (!same_pos)                 stab_cnt_d = 3'd0;
    else if (stab_cnt_q == STAB_N) stab_cnt_d = STAB_N;
    else                           stab_cnt_d = stab_cnt_q + 3'd1;
    pix_valid_d = (stab_cnt_d == STAB_N) && in_range;
  end

  // Stage 1: scrolled, wrapped coordinates
  always_comb begin
    hsum     = {1'b0, hpos} + {1'b0, hscroll_q};
    vsum     = {1'b0, vpos} + {1'b0, vscroll_q};
    x_p1_d   = wrap_x(hsum);
    y_p1_d   = wrap_y(vsum);
    oor_p1_d = !in_range;
  end

  // Stage 2: tile map lookup
  always_comb begin
    map_raddr = MAW'(y_p1_q[VW-1:3]) * COLS_L + MAW'(x_p1_q[HW-1:3]);
    tile_p2_d = map_mem[map_raddr];
    xlo_p2_d  = x_p1_q[2:0];
    ylo_p2_d  = y_p1_q[2:0];
    oor_p2_d  = oor_p1_q;
  end

  // Stage 3: pattern row fetch, both halves
  always_comb begin
    row_p3_d = {pat_mem[{tile_p2_q, ylo_p2_q, 1'b0}], pat_mem[{tile_p2_q, ylo_p2_q, 1'b1}]};
    xlo_p3_d = xlo_p2_q;
    oor_p3_d = oor_p2_q;
  end

  // Stage 4: nibble select and palette lookup into the output register
  always_comb begin
    nib_shift = 5'd28 - {xlo_p3_q, 2'b00};
    nibble    = 4'(row_p3_q >> nib_shift);
    rgb_p4_d  = oor_p3_q ? 16'h0000 : pal_q[nibble];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) pal_q[i] <= '0;
      hpend_q     <= '0;
      vpend_q     <= '0;
      hscroll_q   <= '0;
      vscroll_q   <= '0;
      vsync_q     <= 1'b0;
      prev_h_q    <= '0;
      prev_v_q    <= '0;
      stab_cnt_q  <= '0;
      pix_valid_q <= 1'b0;
      x_p1_q      <= '0;
      y_p1_q      <= '0;
      oor_p1_q    <= 1'b0;
      tile_p2_q   <= '0;
      xlo_p2_q    <= '0;
      ylo_p2_q    <= '0;
      oor_p2_q    <= 1'b0;
      row_p3_q    <= '0;
      xlo_p3_q    <= '0;
      oor_p3_q    <= 1'b0;
      rgb_p4_q    <= '0;
    end else begin
      pal_q       <= pal_d;
      hpend_q     <= hpend_d;
      vpend_q     <= vpend_d;
      hscroll_q   <= hscroll_d;
      vscroll_q   <= vscroll_d;
      vsync_q     <= vsync_d;
      prev_h_q    <= prev_h_d;
      prev_v_q    <= prev_v_d;
      stab_cnt_q  <= stab_cnt_d;
      pix_valid_q <= pix_valid_d;
      x_p1_q      <= x_p1_d;
      y_p1_q      <= y_p1_d;
      oor_p1_q    <= oor_p1_d;
      tile_p2_q   <= tile_p2_d;
      xlo_p2_q    <= xlo_p2_d;
      ylo_p2_q    <= ylo_p2_d;
      oor_p2_q    <= oor_p2_d;
      row_p3_q    <= row_p3_d;
      xlo_p3_q    <= xlo_p3_d;
      oor_p3_q    <= oor_p3_d;
      rgb_p4_q    <= rgb_p4_d;
    end
  end

  assign red       = rgb_p4_q[15:11];
  assign green     = rgb_p4_q[10:5];
  assign blue      = rgb_p4_q[4:0];
  assign pix_valid = pix_valid_q;

endmodule

// File: tb/tb_tilemap_gen.sv
// Bench for tilemap_gen: directed scenarios plus randomized pixels checked
// against an arithmetic model of the tile renderer.
module tb_tilemap_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  hpos;
  logic [7:0]  vpos;
  logic        vsync;
  logic        wr_en;
  logic [1:0]  wr_sel;
  logic [11:0] wr_addr;
  logic [15:0] wr_data;
  logic [4:0]  red;
  logic [5:0]  green;
  logic [4:0]  blue;
  logic        pix_valid;

  always #5 clk = ~clk;

  tilemap_gen #(.WIDTH(320), .HEIGHT(240)) dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .vsync(vsync),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .red(red), .green(green), .blue(blue), .pix_valid(pix_valid)
  );

  typedef struct {
    int h;
    int v;
    int hs;
    int vs;
  } samp_t;

  samp_t       hq[$];
  logic [7:0]  map_m [1200];
  logic [15:0] pat_m [4096];
  logic [15:0] pal_m [16];
  int          pend_h, pend_v, act_h, act_v;
  logic        vs_prev;
  logic [15:0] exp_col;
  logic        exp_pv;
  int          n_chk = 0;
  int          n_pass = 0;

  function automatic logic [15:0] ref_col(samp_t s);
    int x, y, t, base, nib;
    logic [31:0] row;
    if (s.h >= 320 || s.v >= 240) return 16'h0000;
    x    = (s.h + s.hs) % 320;
    y    = (s.v + s.vs) % 240;
    t    = map_m[(y / 8) * 40 + x / 8];
    base = t * 16 + (y % 8) * 2;
    row  = {pat_m[base], pat_m[base + 1]};
    nib  = (row >> (28 - 4 * (x % 8))) & 15;
    return pal_m[nib];
  endfunction

  task automatic model_reset();
    samp_t seed;
    seed = '{0, 0, 0, 0};
    hq.delete();
    hq.push_back(seed);
    for (int i = 0; i < 16; i++) pal_m[i] = 16'h0000;
    pend_h = 0; pend_v = 0; act_h = 0; act_v = 0;
    vs_prev = 1'b0;
  endtask

  task automatic tick();
    samp_t s;
    bit ok;
    int n;
    @(posedge clk);
    s.h = int'(hpos); s.v = int'(vpos); s.hs = act_h; s.vs = act_v;
    hq.push_back(s);
    if (hq.size() > 8) void'(hq.pop_front());
    n = hq.size();
    exp_col = (n >= 4) ? ref_col(hq[n-4]) : 16'h0000;
    exp_pv = 1'b0;
    if (n >= 5) begin
      ok = 1'b1;
      for (int i = n - 5; i < n - 1; i++)
        if (hq[i].h != hq[i+1].h || hq[i].v != hq[i+1].v) ok = 1'b0;
      exp_pv = ok && (s.h < 320) && (s.v < 240);
    end
    if (vsync && !vs_prev) begin
      act_h = (pend_h > 319) ? 319 : pend_h;
      act_v = (pend_v > 239) ? 239 : pend_v;
    end
    vs_prev = vsync;
    if (wr_en) begin
      case (wr_sel)
        2'd0: if (wr_addr < 12'd1200) map_m[wr_addr] = wr_data[7:0];
        2'd1: pat_m[wr_addr] = wr_data;
        2'd2: pal_m[wr_addr[3:0]] = wr_data;
        default: begin
          if (wr_addr == 12'd0) pend_h = int'(wr_data[8:0]);
          if (wr_addr == 12'd1) pend_v = int'(wr_data[7:0]);
        end
      endcase
    end
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic chk_pix(input string tag);
    chk({tag, "_rgb"}, {16'h0, red, green, blue}, {16'h0, exp_col});
    chk({tag, "_pv"}, {31'h0, pix_valid}, {31'h0, exp_pv});
  endtask

  task automatic wr(input logic [1:0] sel, input int a, input int d);
    wr_en = 1'b1; wr_sel = sel; wr_addr = 12'(a); wr_data = 16'(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
  endtask

  task automatic set_pix(input int h, input int v);
    hpos = 9'(h);
    vpos = 8'(v);
  endtask

  task automatic vs_pulse();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b0; hpos = '0; vpos = '0; vsync = 1'b0;
    wr_en = 1'b0; wr_sel = '0; wr_addr = '0; wr_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rgb", {16'h0, red, green, blue}, 32'h0);
    chk("reset_pv", {31'h0, pix_valid}, 32'h0);
    reset = 1'b1;

    // pix_valid must not rise before four stable samples after reset
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_reset_pv_low", {31'h0, pix_valid}, 32'h0);
    end
    tick();
    chk("post_reset_pv_high", {31'h0, pix_valid}, 32'h1);

    for (int i = 0; i < 1200; i++) wr(2'd0, i, int'($urandom_range(0, 255)));
    for (int i = 0; i < 4096; i++) wr(2'd1, i, int'($urandom_range(0, 65535)));
    for (int i = 0; i < 16; i++)   wr(2'd2, i, int'($urandom_range(0, 65535)));

    wr(2'd2, 3, 16'hF800);
    wr(2'd1, 80, 16'h3000);
    wr(2'd1, 81, 16'h0000);
    wr(2'd0, 0, 5);
    wr(2'd2, 0, 16'h0000);
    hold(5);
    chk_pix("r023");
    chk("r023_red", {27'h0, red}, 32'h1F);
    chk("r023_gb", {21'h0, green, blue}, 32'h0);

    set_pix(1, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("r024_pv_low", {31'h0, pix_valid}, 32'h0);
    end
    chk_pix("r024");
    chk("r024_rgb_const", {16'h0, red, green, blue}, 32'h0);
    tick();
    chk("r024_pv_back", {31'h0, pix_valid}, 32'h1);

    wr(2'd0, 1, 6);
    wr(2'd1, 96, 16'h7000);
    wr(2'd2, 7, 16'h07E0);
    wr(2'd3, 0, 8);
    set_pix(0, 0);
    hold(5);
    chk("r025_before_vs", {16'h0, red, green, blue}, 32'hF800);
    vs_pulse();
    hold(5);
    chk_pix("r025_after_vs");
    chk("r025_map1", {16'h0, red, green, blue}, 32'h07E0);
    wr(2'd3, 0, 319);
    set_pix(1, 0);
    vs_pulse();
    hold(5);
    chk("r025_wrap", {16'h0, red, green, blue}, 32'hF800);
    wr(2'd3, 0, 400);
    vs_pulse();
    hold(5);
    chk_pix("hscroll_sat");
    chk("hscroll_sat_const", {16'h0, red, green, blue}, 32'hF800);

    wr(2'd0, 1200, 16'h00AA);
    wr(2'd3, 0, 0);
    vs_pulse();
    set_pix(0, 0);
    hold(5);
    chk("r026_map0", {16'h0, red, green, blue}, 32'hF800);
    set_pix(312, 232);
    hold(5);
    chk_pix("r026_last_tile");
    set_pix(0, 0);
    hold(5);
    wr(2'd2, 3, 16'h001F);
    chk("r026_pal_old", {16'h0, red, green, blue}, 32'hF800);
    tick();
    chk("r026_pal_new", {16'h0, red, green, blue}, 32'h001F);
    chk_pix("r026_model");

    // Asynchronous reset asserted between clock edges
    #2 reset = 1'b0;
    #1;
    chk("r027_async_rgb", {16'h0, red, green, blue}, 32'h0);
    chk("r027_async_pv", {31'h0, pix_valid}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("r027_held_rgb", {16'h0, red, green, blue}, 32'h0);
    reset = 1'b1;
    model_reset();
    hold(5);
    chk_pix("r027_pal_zero");
    chk("r027_rgb_const", {16'h0, red, green, blue}, 32'h0);
    wr(2'd2, 3, 16'hF800);
    hold(4);
    chk("r027_mem_intact", {16'h0, red, green, blue}, 32'hF800);

    wr(2'd3, 1, 1);
    vs_pulse();
    set_pix(0, 239);
    hold(5);
    chk_pix("r028_vwrap");
    chk("r028_vwrap_const", {16'h0, red, green, blue}, 32'hF800);
    set_pix(320, 0);
    hold(5);
    chk("r028_oor_rgb", {16'h0, red, green, blue}, 32'h0);
    chk("r028_oor_pv", {31'h0, pix_valid}, 32'h0);
    set_pix(0, 240);
    hold(5);
    chk_pix("vpos_oor");

    for (int k = 0; k < 40; k++) begin
      int sel;
      sel = int'($urandom_range(0, 4));
      if (sel == 0) wr(2'd2, int'($urandom_range(0, 15)), int'($urandom_range(0, 65535)));
      if (sel == 1) wr(2'd0, int'($urandom_range(0, 1199)), int'($urandom_range(0, 255)));
      if (sel == 2) wr(2'd3, int'($urandom_range(2, 4095)), int'($urandom_range(0, 65535)));
      if (sel >= 3) begin
        wr(2'd3, 0, int'($urandom_range(0, 511)));
        wr(2'd3, 1, int'($urandom_range(0, 255)));
        vs_pulse();
      end
      if ($urandom_range(0, 9) == 0)
        set_pix(int'($urandom_range(0, 511)), int'($urandom_range(0, 255)));
      else
        set_pix(int'($urandom_range(0, 319)), int'($urandom_range(0, 239)));
      hold(5);
      chk_pix("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
